// File: rtl/imem_loader_pkg.sv
// Shared processor constants and loader FSM encoding used by the
// instruction-memory loader and its byte packer.
package imem_loader_pkg;

  localparam int ADDR_W         = 4;
  localparam int IMEM_DEPTH     = 1 << ADDR_W;
  localparam int BYTES_PER_WORD = 4;
  localparam int WC_W           = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_e;

  // A load request is legal only for 1..depth words.
  function automatic logic count_ok(input logic [WC_W-1:0] wc, input int depth);
    return (wc != '0) && (int'(wc) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte assembler: the first byte shifted in ends up in the
// top byte of the word once NBYTES bytes have been accepted.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD,
  parameter int CNT_W  = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [8*NBYTES-1:0]   word,
  output logic [CNT_W-1:0]      cnt,
  output logic                  full
);

  assign full = (cnt == CNT_W'(NBYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en && !full) begin
      word <= {word[8*NBYTES-9:0], byte_in};
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory word by word, holding the CPU in
// reset until the requested number of words has been written.
module imem_loader #(
  parameter int ADDR_W     = imem_loader_pkg::ADDR_W,
  parameter int IMEM_DEPTH = imem_loader_pkg::IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);
  import imem_loader_pkg::*;

  localparam int PK_CW = $clog2(BYTES_PER_WORD + 1);

  ld_state_e         state, state_nx;
  logic [ADDR_W-1:0] word_addr;
  logic [4:0]        words_done;
  logic [4:0]        wc_lat;
  logic              load_go;
  logic              byte_fire;
  logic              last_word;
  logic              cnt_good;
  logic [31:0]       pk_word;
  logic [PK_CW-1:0]  pk_cnt;
  logic              pk_full;
  logic              pk_clr;

  assign cnt_good  = count_ok(word_count, IMEM_DEPTH);
  assign byte_fire = in_ready && in_valid;
  assign last_word = ((words_done + 5'd1) == wc_lat);
  assign pk_clr    = load_go || (state == ST_WRITE);

  byte_packer #(.NBYTES(BYTES_PER_WORD), .CNT_W(PK_CW)) u_packer (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (pk_clr),
    .shift_en (byte_fire),
    .byte_in  (in_byte),
    .word     (pk_word),
    .cnt      (pk_cnt),
    .full     (pk_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_go  = 1'b0;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          if (cnt_good) begin
            state_nx = ST_LOAD;
            load_go  = 1'b1;
          end else begin
            state_nx = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        if (byte_fire && (pk_cnt == PK_CW'(BYTES_PER_WORD - 1)))
          state_nx = ST_WRITE;
      end
      ST_WRITE: state_nx = last_word ? ST_RUN : ST_LOAD;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Address stops at the final word so a full-depth load never wraps to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_addr  <= '0;
      words_done <= '0;
      wc_lat     <= '0;
    end else if (load_go) begin
      word_addr  <= '0;
      words_done <= '0;
      wc_lat     <= word_count;
    end else if (state == ST_WRITE) begin
      words_done <= words_done + 5'd1;
      if (!last_word) word_addr <= word_addr + 1'b1;
    end
  end

  assign in_ready   = (state == ST_LOAD);
  assign imem_we    = (state == ST_WRITE) && pk_full;
  assign imem_addr  = word_addr;
  assign imem_wdata = pk_word;
  assign cpu_rst_n  = (state == ST_RUN);
  assign done       = (state == ST_RUN);
  assign err        = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as the
// stimulus is driven and checked when the write strobe appears.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        err;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  compared = 0;
  int  mism     = 0;
  int  n_we     = 0;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      n_we++;
      chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.a));
        chk("wr_data", imem_wdata, e.d);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [4:0] wc);
    start      = 1'b1;
    word_count = wc;
    cyc(1);
    start      = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 50) begin
      cyc(1);
      t++;
    end
    chk("ready_timeout", 32'(t < 50), 32'd1);
    cyc(1);
    if (gap > 0) begin
      in_valid = 1'b0;
      cyc(gap);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpu_rst_n"},  32'(cpu_rst_n),  32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nom [8];
    logic [7:0] b;
    int n0;
    nom = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};

    rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_byte = '0;
    #2 rst = 1'b0;
    cyc(2);
    chk_reset_vals("rst");
    rst = 1'b1;
    cyc(1);

    // Nominal two-word load, in_valid held high
    exp_q.push_back('{4'd0, 32'h20080005});
    exp_q.push_back('{4'd1, 32'h8C090004});
    n0 = n_we;
    do_start(5'd2);
    chk("load_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) push_byte(nom[i], 0);
    in_valid = 1'b0;
    chk("write_not_done", 32'(done), 32'd0);
    cyc(1);
    chk("nom_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_we_count", 32'(n_we - n0), 32'd2);

    // Restart from RUN with stalls; a start pulse mid-load must be ignored
    exp_q.push_back('{4'd0, 32'h20080005});
    exp_q.push_back('{4'd1, 32'h8C090004});
    n0 = n_we;
    do_start(5'd2);
    chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin start = 1'b1; word_count = 5'd1; end
      push_byte(nom[i], (i % 2 == 0) ? 2 : 0);
      start = 1'b0;
    end
    in_valid = 1'b0;
    cyc(1);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_we_count", 32'(n_we - n0), 32'd2);

    // Bad counts go to ERR without writing; a good count recovers
    n0 = n_we;
    do_start(5'd0);
    chk("bad0_err", 32'(err), 32'd1);
    chk("bad0_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("bad0_ready", 32'(in_ready), 32'd0);
    do_start(5'd17);
    chk("bad17_err", 32'(err), 32'd1);
    cyc(2);
    chk("bad_we_count", 32'(n_we - n0), 32'd0);
    exp_q.push_back('{4'd0, 32'hAABBCCDD});
    do_start(5'd1);
    chk("recover_err", 32'(err), 32'd0);
    push_byte(8'hAA, 0); push_byte(8'hBB, 0); push_byte(8'hCC, 0); push_byte(8'hDD, 0);
    in_valid = 1'b0;
    cyc(1);
    chk("recover_done", 32'(done), 32'd1);
    chk("recover_we_count", 32'(n_we - n0), 32'd1);

    // Full depth: 16 words at addresses 0..15
    for (int w = 0; w < 16; w++) begin
      wr_t e;
      e.a = 4'(w);
      e.d = '0;
      for (int k = 0; k < 4; k++) e.d = {e.d[23:0], 8'(w * 4 + k) ^ 8'h5A};
      exp_q.push_back(e);
    end
    n0 = n_we;
    do_start(5'd16);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(w * 4 + k) ^ 8'h5A;
        if (w == 2 && k == 0) begin start = 1'b1; word_count = 5'd1; end
        push_byte(b, 0);
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    cyc(1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_we_count", 32'(n_we - n0), 32'd16);

    // Reset after 6 of 8 bytes: only the first word reaches memory
    exp_q.push_back('{4'd0, 32'h11223344});
    n0 = n_we;
    do_start(5'd2);
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0);
    push_byte(8'h44, 0); push_byte(8'h55, 0); push_byte(8'h66, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_we_count", 32'(n_we - n0), 32'd1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    exp_q.push_back('{4'd0, 32'hDEADBEEF});
    n0 = n_we;
    do_start(5'd1);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0); push_byte(8'hBE, 0); push_byte(8'hEF, 0);
    in_valid = 1'b0;
    cyc(1);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_we_count", 32'(n_we - n0), 32'd1);

    cyc(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
